knight_motion_ctrl: RTL and testbench
=====================================

# knight_motion_ctrl

Per-frame motion and action sequencer for the player knight. Once per `frame_clk` it samples the keyboard `keycode` and the `on_ground` collision flag, then runs a ground/rise/fall state machine with gravity, plus an attack timer with cooldown. It produces signed X/Y velocities that the player position datapath adds to its position registers, and facing/attack flags for the sprite renderer.

## Interface
Parameters:
- `GRAVITY`, default 1: Y velocity increment per frame while airborne.
- `JUMP_V`, default 12: magnitude of the initial upward velocity.
- `MAX_FALL`, default 8: terminal downward velocity.
- `RUN_V`, default 3: horizontal speed.
- `ATTACK_FRAMES`, default 6: number of frames `attack_active` stays high.
- `COOLDOWN_FRAMES`, default 10: lockout after an attack ends.

Ports:
- `frame_clk` in 1: frame tick clock, one edge per video frame.
- `Reset` in 1: reset, asynchronous, active-high.
- `keycode` in 8: USB HID code. A=0x04, D=0x07, J (attack)=0x0D, space (jump)=0x2C, 0x00=none.
- `on_ground` in 1: player is resting on a floor this frame.
- `x_vel` out 10: signed two's-complement X velocity.
- `y_vel` out 10: signed two's-complement Y velocity, positive is down.
- `facing_left` out 1: sprite facing direction.
- `attack_active` out 1: slash hitbox enable.
- `motion_state` out 2: GROUND=0, RISE=1, FALL=2.

## Operation
- All outputs are registered and updated on `posedge frame_clk`.
- Reset values:
  - `x_vel=0`, `y_vel=0`, `facing_left=0`, `attack_active=0`, `motion_state=GROUND`.
  - Attack and cooldown counters are 0.
  - The previous-keycode register is 0x00.
- Edge detect: a key "press" means `keycode` equals that code this frame and the previous-keycode register did not. Holding a key does not retrigger.
- GROUND state:
  - A jump press sets `y_vel=-JUMP_V` and moves to RISE.
  - Otherwise, if `!on_ground`, move to FALL with `y_vel=0` (walked off a ledge).
  - Otherwise `y_vel=0`.
- RISE state:
  - If `y_vel+GRAVITY >= 0`, set `y_vel=0` and move to FALL.
  - Otherwise `y_vel += GRAVITY`.
- FALL state:
  - If `on_ground`, set `y_vel=0` and move to GROUND.
  - Otherwise `y_vel = min(y_vel+GRAVITY, MAX_FALL)`.
- Horizontal velocity:
  - A sets `x_vel=-RUN_V` and `facing_left=1`.
  - D sets `x_vel=+RUN_V` and `facing_left=0`.
  - With no A/D key: `x_vel=0` in GROUND; in RISE/FALL, `x_vel` holds its previous value (air momentum).
  - A grounded attack forces `x_vel=0` for every frame `attack_active=1`.
- Attack sequencing:
  - A J press is accepted only when both the attack and cooldown counters are 0. It loads the attack counter with ATTACK_FRAMES and sets `attack_active=1`.
  - The attack counter decrements once per frame. `attack_active` deasserts on the frame it reaches 0, and on that same frame the cooldown counter loads COOLDOWN_FRAMES.
  - J presses during the attack or cooldown are ignored, not queued.
  - Attacks are legal in any motion state and do not change `motion_state`.
- Simultaneous events:
  - In GROUND, a jump press wins over `!on_ground`.
  - In FALL, `on_ground` wins over gravity.
  - Reset mid-attack or mid-air clears everything to the reset values.
- Arithmetic: 10-bit signed. `|JUMP_V|`, `MAX_FALL` and `RUN_V` must be at most 255, so no overflow is possible. Downstream adds `x_vel`/`y_vel` to 10-bit positions modulo 1024.

## Timing
- Latency: one frame from input to output. A key pressed on frame N is visible on the outputs after edge N.
- Jump from rest: `y_vel` reads -12, -11, …, -1 (12 RISE frames), then 0 in FALL, then 1..8 and holds at 8.
- Attack: `attack_active` is high for exactly ATTACK_FRAMES edges. The next J press is accepted no earlier than ATTACK_FRAMES+COOLDOWN_FRAMES frames after the first.
- No handshakes. Inputs are sampled once per edge.

## Configuration
- `KNIGHT_DOUBLE_JUMP_EN`
  - Defined: one extra jump press is accepted in RISE or FALL. It sets `y_vel=-JUMP_V`, enters RISE, and consumes an air-jump token. The token is restored on entry to GROUND and cleared by Reset.
  - Undefined: jump presses while airborne are ignored, and no token register exists.

## Structure
- `knight_pkg` holds:
  - the `motion_state_t` enum;
  - keycode constants `KEY_A`, `KEY_D`, `KEY_J`, `KEY_SPACE`;
  - the signed velocity typedef `vel_t` (`logic signed [9:0]`).
- Sub-module `frame_down_counter` (load, decrement to 0, `zero` flag): instantiated twice, once for the attack counter and once for the cooldown counter.

## Test plan
- Reset asserted mid-jump (`y_vel=-5`, RISE) → all outputs 0/GROUND on the next observation; no counter is left running.
- `on_ground=1`, hold 0x2C for 20 frames → exactly one jump: `y_vel` runs -12…-1, then 0, 1, … 8 and saturates.
- Grounded, 0x07 for 3 frames then 0x00 → `x_vel` reads 3, 3, 3, then 0; `facing_left=0` throughout.
- Airborne, 0x04 then 0x00 → `x_vel` stays -3 and `facing_left=1` until landing, then 0.
- Grounded D held, J pressed 3 times 4 frames apart → `attack_active` high for frames 1-6 only with `x_vel=0` during them; the 2nd and 3rd presses are ignored.
- With `KNIGHT_DOUBLE_JUMP_EN`: jump, release, jump again while in FALL → `y_vel` reloads -12. A third press in air is ignored.

Source files
------------

// File: rtl/knight_pkg.sv
// knight_pkg: shared types and constants for the knight motion controller.
// Holds the motion state enum, HID keycodes, the signed velocity type and
// the press-edge helper used by the sequencer.
package knight_pkg;

  typedef logic signed [9:0] vel_t;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } motion_state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_J     = 8'h0D;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  // Width of the attack and cooldown frame counters.
  localparam int CNT_W = 8;

  // A press is a key that is down this frame but was not down last frame.
  function automatic logic key_pressed(input logic [7:0] cur,
                                       input logic [7:0] prev,
                                       input logic [7:0] code);
    return (cur == code) && (prev != code);
  endfunction

endpackage

// File: rtl/knight_motion_ctrl_if.sv
// knight_motion_ctrl_if: per-frame inputs (keyboard, floor contact) and the
// velocity/sprite outputs of the knight motion controller.
// master = stimulus/system side, slave = the controller.
interface knight_motion_ctrl_if;
  import knight_pkg::*;

  logic [7:0]    keycode;
  logic          on_ground;
  vel_t          x_vel;
  vel_t          y_vel;
  logic          facing_left;
  logic          attack_active;
  motion_state_t motion_state;

  modport master (
    output keycode, on_ground,
    input  x_vel, y_vel, facing_left, attack_active, motion_state
  );

  modport slave (
    input  keycode, on_ground,
    output x_vel, y_vel, facing_left, attack_active, motion_state
  );

endinterface

// File: rtl/frame_down_counter.sv
// frame_down_counter: loadable frame counter that decrements to zero and
// parks there. Load has priority over decrement. zero flags an idle counter.
module frame_down_counter #(
  parameter int W = 8
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // Count register: load, otherwise step down until zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/knight_motion_ctrl.sv
// knight_motion_ctrl: per-frame motion and action sequencer for the knight.
// Samples keycode/on_ground once per frame_clk edge, runs the
// GROUND/RISE/FALL machine with gravity, drives horizontal run velocity and
// sequences the attack/cooldown timers.
// Optional build macro: KNIGHT_DOUBLE_JUMP_EN -- allows one extra jump while
// airborne, re-armed every frame spent on the ground.
module knight_motion_ctrl
  import knight_pkg::*;
#(
  parameter int GRAVITY         = 1,
  parameter int JUMP_V          = 12,
  parameter int MAX_FALL        = 8,
  parameter int RUN_V           = 3,
  parameter int ATTACK_FRAMES   = 6,
  parameter int COOLDOWN_FRAMES = 10
) (
  input logic                 frame_clk,
  input logic                 Reset,
  knight_motion_ctrl_if.slave bus
);

  localparam vel_t VEL_ZERO  = '0;
  localparam vel_t GRAV_V    = vel_t'(GRAVITY);
  localparam vel_t JUMP_INIT = vel_t'(-JUMP_V);
  localparam vel_t FALL_MAX  = vel_t'(MAX_FALL);
  localparam vel_t RUN_POS   = vel_t'(RUN_V);
  localparam vel_t RUN_NEG   = vel_t'(-RUN_V);

  logic [7:0]       prev_key;
  motion_state_t    state, state_next;
  vel_t             y_next, x_next, y_inc;
  logic             facing_next;
  logic             jump_press, j_press, air_jump;
  logic             atk_load, cool_load, atk_active_next;
  logic [CNT_W-1:0] atk_count, cool_count;
  logic             atk_zero, cool_zero;

  assign jump_press = key_pressed(bus.keycode, prev_key, KEY_SPACE);
  assign j_press    = key_pressed(bus.keycode, prev_key, KEY_J);
  assign y_inc      = bus.y_vel + GRAV_V;

  // Attack is accepted only with both timers idle; the cooldown starts on the
  // edge where the attack counter steps from 1 to 0.
  assign atk_load        = j_press && atk_zero && cool_zero;
  assign cool_load       = (atk_count == CNT_W'(1));
  assign atk_active_next = atk_load || (atk_count > CNT_W'(1));

  frame_down_counter #(.W(CNT_W)) u_attack_cnt (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (atk_load),
    .load_val  (CNT_W'(ATTACK_FRAMES)),
    .count     (atk_count),
    .zero      (atk_zero)
  );

  frame_down_counter #(.W(CNT_W)) u_cooldown_cnt (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (cool_load),
    .load_val  (CNT_W'(COOLDOWN_FRAMES)),
    .count     (cool_count),
    .zero      (cool_zero)
  );

  // Attack and cooldown phases are mutually exclusive by construction.
  assert property (@(posedge frame_clk) disable iff (Reset)
                   !((atk_count != '0) && (cool_count != '0)));

`ifdef KNIGHT_DOUBLE_JUMP_EN
  logic air_token;

  assign air_jump = jump_press && air_token && (state != GROUND);

  // Air-jump token: re-armed while grounded, spent by an airborne jump.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      air_token <= 1'b0;
    else if (state_next == GROUND)
      air_token <= 1'b1;
    else if (air_jump)
      air_token <= 1'b0;
  end
`else
  assign air_jump = 1'b0;
`endif

  // Vertical motion: next state and Y velocity with gravity and terminal speed.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    y_next     = bus.y_vel;
    case (state)
      GROUND: begin
        if (jump_press) begin
          state_next = RISE;
          y_next     = JUMP_INIT;
        end else if (!bus.on_ground) begin
          state_next = FALL;
          y_next     = VEL_ZERO;
        end else begin
          y_next = VEL_ZERO;
        end
      end
      RISE: begin
        if (air_jump) begin
          y_next = JUMP_INIT;
        end else if (y_inc >= VEL_ZERO) begin
          state_next = FALL;
          y_next     = VEL_ZERO;
        end else begin
          y_next = y_inc;
        end
      end
      FALL: begin
        if (bus.on_ground) begin
          state_next = GROUND;
          y_next     = VEL_ZERO;
        end else if (air_jump) begin
          state_next = RISE;
          y_next     = JUMP_INIT;
        end else if (y_inc > FALL_MAX) begin
          y_next = FALL_MAX;
        end else begin
          y_next = y_inc;
        end
      end
      default: begin
        state_next = GROUND;
        y_next     = VEL_ZERO;
      end
    endcase
  end

  // Horizontal motion: run keys win, air keeps momentum, ground stops, and a
  // grounded attack pins the knight in place.
  always_comb begin
    x_next      = bus.x_vel;
    facing_next = bus.facing_left;
    if (bus.keycode == KEY_A) begin
      x_next      = RUN_NEG;
      facing_next = 1'b1;
    end else if (bus.keycode == KEY_D) begin
      x_next      = RUN_POS;
      facing_next = 1'b0;
    end else if (state_next == GROUND) begin
      x_next = VEL_ZERO;
    end
    if ((state_next == GROUND) && atk_active_next)
      x_next = VEL_ZERO;
  end

  // Output and history registers, all updated once per frame.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev_key          <= KEY_NONE;
      state             <= GROUND;
      bus.x_vel         <= VEL_ZERO;
      bus.y_vel         <= VEL_ZERO;
      bus.facing_left   <= 1'b0;
      bus.attack_active <= 1'b0;
    end else begin
      prev_key          <= bus.keycode;
      state             <= state_next;
      bus.x_vel         <= x_next;
      bus.y_vel         <= y_next;
      bus.facing_left   <= facing_next;
      bus.attack_active <= atk_active_next;
    end
  end

  assign bus.motion_state = state;

endmodule

// File: tb/tb_knight_motion_ctrl.sv
// tb_knight_motion_ctrl: directed vectors for knight_motion_ctrl. Each step
// drives one frame of inputs and queues the hand-computed outputs expected
// after the next edge; a monitor pops and compares just after every edge.
module tb_knight_motion_ctrl;
  import knight_pkg::*;

  logic frame_clk = 1'b0;
  logic Reset;

  knight_motion_ctrl_if bus ();

  knight_motion_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int            id;
    vel_t          x;
    vel_t          y;
    logic          f;
    logic          a;
    motion_state_t s;
  } exp_t;

  exp_t sb[$];
  int   n_issued = 0;
  int   n_vec    = 0;
  int   n_err    = 0;

  // One frame: drive inputs on the falling edge, queue the expected outputs.
  task automatic step(input logic rst, input logic [7:0] k, input logic og,
                      input int ex, input int ey, input logic ef,
                      input logic ea, input motion_state_t es);
    exp_t e;
    @(negedge frame_clk);
    Reset         = rst;
    bus.keycode   = k;
    bus.on_ground = og;
    e.id = n_issued;
    e.x  = vel_t'(ex);
    e.y  = vel_t'(ey);
    e.f  = ef;
    e.a  = ea;
    e.s  = es;
    sb.push_back(e);
    n_issued++;
  endtask

  // Monitor: compare registered outputs 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge frame_clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (bus.x_vel !== e.x || bus.y_vel !== e.y || bus.facing_left !== e.f ||
            bus.attack_active !== e.a || bus.motion_state !== e.s) begin
          n_err++;
          $display("FAIL vec%0d: got x=%0d y=%0d face=%0b atk=%0b st=%0d, want x=%0d y=%0d face=%0b atk=%0b st=%0d",
                   e.id, bus.x_vel, bus.y_vel, bus.facing_left, bus.attack_active,
                   bus.motion_state, e.x, e.y, e.f, e.a, e.s);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset         = 1'b1;
    bus.keycode   = KEY_NONE;
    bus.on_ground = 1'b1;

    // Reset state
    step(1, KEY_NONE, 1, 0, 0, 0, 0, GROUND);

    // Grounded D for 3 frames, then release
    for (int i = 0; i < 3; i++) step(0, KEY_D, 1, 3, 0, 0, 0, GROUND);
    step(0, KEY_NONE, 1, 0, 0, 0, 0, GROUND);

    // Grounded A sets facing, which holds after release; D clears it
    step(0, KEY_A,    1, -3, 0, 1, 0, GROUND);
    step(0, KEY_NONE, 1,  0, 0, 1, 0, GROUND);
    step(0, KEY_D,    1,  3, 0, 0, 0, GROUND);

    // D held with J presses 4 frames apart: only the first is accepted
    step(0, KEY_J, 1, 0, 0, 0, 1, GROUND);
    for (int i = 0; i < 3; i++) step(0, KEY_D, 1, 0, 0, 0, 1, GROUND);
    step(0, KEY_J, 1, 0, 0, 0, 1, GROUND);
    step(0, KEY_D, 1, 0, 0, 0, 1, GROUND);
    step(0, KEY_D, 1, 3, 0, 0, 0, GROUND);
    step(0, KEY_D, 1, 3, 0, 0, 0, GROUND);
    step(0, KEY_J, 1, 0, 0, 0, 0, GROUND);
    for (int i = 0; i < 7; i++) step(0, KEY_D, 1, 3, 0, 0, 0, GROUND);
    // Last cooldown frame: press ignored; two frames later it is accepted
    step(0, KEY_J,    1, 0, 0, 0, 0, GROUND);
    step(0, KEY_NONE, 1, 0, 0, 0, 0, GROUND);
    step(0, KEY_J,    1, 0, 0, 0, 1, GROUND);
    step(0, KEY_NONE, 1, 0, 0, 0, 1, GROUND);

    // Reset mid-attack; a J right after reset must be accepted immediately
    step(1, KEY_NONE, 1, 0, 0, 0, 0, GROUND);
    step(0, KEY_J,    1, 0, 0, 0, 1, GROUND);
    for (int i = 0; i < 5; i++) step(0, KEY_NONE, 1, 0, 0, 0, 1, GROUND);
    step(0, KEY_NONE, 1, 0, 0, 0, 0, GROUND);

    // Space held 20 frames: one jump, -12..-1, 0, then 1..8 saturating
    for (int i = 0; i < 24; i++) begin
      int            ey;
      motion_state_t es;
      if (i < 12) begin
        ey = -12 + i;
        es = RISE;
      end else if (i == 12) begin
        ey = 0;
        es = FALL;
      end else begin
        ey = (i - 12 > 8) ? 8 : i - 12;
        es = FALL;
      end
      step(0, (i < 20) ? KEY_SPACE : KEY_NONE, (i == 0), 0, ey, 0, 0, es);
    end
    step(0, KEY_NONE, 1, 0, 0, 0, 0, GROUND);

    // Jump, release, then jump presses while airborne
    step(0, KEY_SPACE, 1, 0, -12, 0, 0, RISE);
    for (int i = 1; i < 12; i++) step(0, KEY_NONE, 0, 0, -12 + i, 0, 0, RISE);
    step(0, KEY_NONE, 0, 0, 0, 0, 0, FALL);
    step(0, KEY_NONE, 0, 0, 1, 0, 0, FALL);
`ifdef KNIGHT_DOUBLE_JUMP_EN
    step(0, KEY_SPACE, 0, 0, -12, 0, 0, RISE);
    step(0, KEY_NONE,  0, 0, -11, 0, 0, RISE);
    step(0, KEY_SPACE, 0, 0, -10, 0, 0, RISE);
    step(0, KEY_NONE,  1, 0,  -9, 0, 0, RISE);
`else
    step(0, KEY_SPACE, 0, 0, 2, 0, 0, FALL);
    step(0, KEY_NONE,  0, 0, 3, 0, 0, FALL);
    step(0, KEY_SPACE, 0, 0, 4, 0, 0, FALL);
    step(0, KEY_NONE,  1, 0, 0, 0, 0, GROUND);
`endif
    step(1, KEY_NONE, 1, 0, 0, 0, 0, GROUND);
    step(0, KEY_NONE, 1, 0, 0, 0, 0, GROUND);

    // Walk off a ledge with A, release: momentum and facing held until landing
    step(0, KEY_A,    0, -3, 0, 1, 0, FALL);
    step(0, KEY_NONE, 0, -3, 1, 1, 0, FALL);
    step(0, KEY_NONE, 0, -3, 2, 1, 0, FALL);
    step(0, KEY_NONE, 1,  0, 0, 1, 0, GROUND);

    // Jump press wins over !on_ground; reset at y_vel=-5 in RISE
    step(0, KEY_SPACE, 0, 0, -12, 1, 0, RISE);
    for (int i = 1; i < 8; i++) step(0, KEY_SPACE, 0, 0, -12 + i, 1, 0, RISE);
    step(1, KEY_NONE, 1, 0, 0, 0, 0, GROUND);
    step(0, KEY_NONE, 1, 0, 0, 0, 0, GROUND);

    @(posedge frame_clk);
    #3;
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d unchecked vectors, want 0", sb.size());
      n_err += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
